// File: rtl/apb_cmd_master.sv
// Queued APB master: a command FIFO feeds an FSM that runs APB writes/reads,
// waits for an interrupt edge or delays, and reports one response per command.
module apb_cmd_master #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 91,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [ADDR_W-1:0]          cmd_addr,
    input  logic [DATA_W-1:0]          cmd_wdata,
    output logic [ADDR_W-1:0]          paddr,
    output logic                       psel,
    output logic                       penable,
    output logic                       pwrite,
    output logic [DATA_W-1:0]          pwdata,
    input  logic [DATA_W-1:0]          prdata,
    input  logic                       pready,
    input  logic                       interupt,
    output logic                       rsp_valid,
    output logic [1:0]                 rsp_op,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_err,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int FCW       = $clog2(DEPTH + 1);
    localparam int TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit TO_EN     = (TIMEOUT > 0);

    localparam logic [TW-1:0]    TO_LAST = TO_LAST_I[TW-1:0];
    localparam logic [TW-1:0]    T_ONE   = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [FCW-1:0]   F_ONE   = {{(FCW-1){1'b0}}, 1'b1};
    localparam logic [FCW-1:0]   DEPTH_C = DEPTH[FCW-1:0];
    localparam logic [PTR_W-1:0] P_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WAIT  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_ACCESS   = 3'd2,
        ST_WAIT_IRQ = 3'd3,
        ST_DELAY    = 3'd4
    } state_t;

    logic [1:0]        op_mem   [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [FCW-1:0]   count_r;
    logic [FCW-1:0]   count_nxt_s;
    logic             ready_r;
    logic             push_s;
    logic             pop_s;

    state_t           state_r;
    logic [1:0]       op_r;
    logic [TW-1:0]    tcnt_r;
    logic [CNT_W-1:0] dcnt_r;
    logic             irq_prev_r;
    logic             timeout_s;
    logic [1:0]       head_op_s;
    logic [CNT_W-1:0] head_cnt_s;

    assign push_s     = cmd_valid & ready_r;
    assign pop_s      = (state_r == ST_IDLE) && (count_r != '0);
    assign head_op_s  = op_mem[rd_ptr_r];
    assign head_cnt_s = data_mem[rd_ptr_r][CNT_W-1:0];
    assign timeout_s  = TO_EN && (tcnt_r == TO_LAST);

    assign cmd_ready  = ready_r;
    assign fifo_count = count_r;
    assign busy       = (state_r != ST_IDLE) || (count_r != '0);

    // next FIFO occupancy from this cycle's push/pop
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + F_ONE;
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - F_ONE;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // FIFO pointers, occupancy and registered ready (low while in reset)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            ready_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + P_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + P_ONE;
            end
            count_r <= count_nxt_s;
            ready_r <= (count_nxt_s < DEPTH_C);
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            op_mem[wr_ptr_r]   <= cmd_op;
            addr_mem[wr_ptr_r] <= cmd_addr;
            data_mem[wr_ptr_r] <= cmd_wdata;
        end
    end

    // command sequencer with registered APB and response outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            op_r       <= 2'd0;
            tcnt_r     <= '0;
            dcnt_r     <= '0;
            irq_prev_r <= 1'b0;
            paddr      <= '0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            rsp_valid  <= 1'b0;
            rsp_op     <= 2'd0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_op    <= 2'd0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        op_r   <= head_op_s;
                        tcnt_r <= '0;
                        case (head_op_s)
                            OP_WRITE, OP_READ: begin
                                paddr   <= addr_mem[rd_ptr_r];
                                pwdata  <= data_mem[rd_ptr_r];
                                pwrite  <= (head_op_s == OP_WRITE);
                                psel    <= 1'b1;
                                penable <= 1'b0;
                                state_r <= ST_SETUP;
                            end
                            OP_WAIT: begin
                                // a level already high here must not count as an edge
                                irq_prev_r <= interupt;
                                state_r    <= ST_WAIT_IRQ;
                            end
                            default: begin
                                dcnt_r  <= (head_cnt_s == '0) ? C_ONE : head_cnt_s;
                                state_r <= ST_DELAY;
                            end
                        endcase
                    end
                end
                ST_SETUP: begin
                    penable <= 1'b1;
                    tcnt_r  <= '0;
                    state_r <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready wins over a timeout expiring in the same cycle
                    if (pready) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_op    <= op_r;
                        rsp_data  <= (op_r == OP_READ) ? prdata : '0;
                        state_r   <= ST_IDLE;
                    end else if (timeout_s) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_op    <= op_r;
                        rsp_err   <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        tcnt_r <= tcnt_r + T_ONE;
                    end
                end
                ST_WAIT_IRQ: begin
                    irq_prev_r <= interupt;
                    if (interupt && !irq_prev_r) begin
                        rsp_valid <= 1'b1;
                        rsp_op    <= op_r;
                        state_r   <= ST_IDLE;
                    end else if (timeout_s) begin
                        rsp_valid <= 1'b1;
                        rsp_op    <= op_r;
                        rsp_err   <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        tcnt_r <= tcnt_r + T_ONE;
                    end
                end
                ST_DELAY: begin
                    if (dcnt_r == C_ONE) begin
                        rsp_valid <= 1'b1;
                        rsp_op    <= op_r;
                        state_r   <= ST_IDLE;
                    end else begin
                        dcnt_r <= dcnt_r - C_ONE;
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
